// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: types and defaults shared by the FIFO AXI-Stream adapters
package axis_fifo_pkg;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {OCC0, OCC1, OCC2} occ_t;
endpackage

// File: rtl/axis_fifo_rd_adapter_if.sv
// axis_fifo_rd_adapter_if: AXI-Stream bus between the read adapter and its sink
interface axis_fifo_rd_adapter_if import axis_fifo_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_skid_buf2.sv
// axis_skid_buf2: 2-entry output buffer with occupancy FSM; head is b0
module axis_skid_buf2 import axis_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output occ_t              occ_o
);
  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      occ_q <= OCC0;
      b0_q  <= '0;
      b1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
    end
  // the incoming word lands in the first slot that is free after the pop
  always_comb begin
    occ_d = occ_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    case (occ_q)
      OCC0: if (push_i) begin
        occ_d = OCC1;
        b0_d  = din_i;
      end
      OCC1: if (push_i && !pop_i) begin
        occ_d = OCC2;
        b1_d  = din_i;
      end else if (pop_i && !push_i) begin
        occ_d = OCC0;
      end else if (push_i) begin
        b0_d  = din_i;
      end
      OCC2: if (pop_i) begin
        occ_d = OCC1;
        b0_d  = b1_q;
      end
      default: occ_d = OCC0;
    endcase
  end
  assign dout_o = b0_q;
  assign occ_o  = occ_q;
endmodule

// File: rtl/axis_fifo_rd_adapter.sv
// axis_fifo_rd_adapter: async_fifo_core read port to AXI-Stream master, full throughput.
// Define AXIS_FIFO_RD_TLAST_EN to frame the stream with tlast every PKT_LEN beats.
module axis_fifo_rd_adapter import axis_fifo_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_LEN = 16
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    fifo_empty,
  input  logic [DATA_W-1:0]       fifo_rdata,
  output logic                    fifo_ren,
  axis_fifo_rd_adapter_if.master  m_axis
);
  occ_t occ;
  logic pend_q;
  logic pop;
  assign pop = m_axis.tvalid && m_axis.tready;
  // buffered + in-flight words, after this cycle's pop, must leave room for one more
  assign fifo_ren = rrst_n && !fifo_empty &&
                    ({1'b0, occ} + {2'b0, pend_q} < 3'd2 + {2'b0, pop});
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) pend_q <= 1'b0;
    else         pend_q <= fifo_ren;
  axis_skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .push_i (pend_q),
    .pop_i  (pop),
    .din_i  (fifo_rdata),
    .dout_o (m_axis.tdata),
    .occ_o  (occ)
  );
  assign m_axis.tvalid = occ != OCC0;
`ifdef AXIS_FIFO_RD_TLAST_EN
  localparam int CNT_W = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  assign beat_cnt_d = !pop ? beat_cnt_q : beat_cnt_q == CNT_LAST ? '0 : beat_cnt_q + 1'b1;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  assign m_axis.tlast = m_axis.tvalid && beat_cnt_q == CNT_LAST;
`else
  logic unused_pkt_len;
  assign unused_pkt_len = ^PKT_LEN;
  assign m_axis.tlast   = 1'b0;
`endif
endmodule

// File: tb/tb_axis_fifo_rd_adapter.sv
// tb_axis_fifo_rd_adapter: directed bench for the read-side AXI-Stream adapter
module tb_axis_fifo_rd_adapter;
  localparam int DW = 8;
  localparam int PL = 4;
  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic          fifo_empty;
  logic          fifo_ren;
  logic [DW-1:0] fifo_rdata = '0;
  logic [DW-1:0] mem [256];
  int            wr_n = 0;
  int            rd_n = 0;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            ngot = 0;
  int            nren = 0;
  int            lvl = 0;
  int            viol = 0;
  int            stab = 0;
  logic [DW-1:0] got [512];
  logic          gl  [512];
  int            gc  [512];
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;

  axis_fifo_rd_adapter_if #(.DATA_W(DW)) m_axis ();

  axis_fifo_rd_adapter #(.DATA_W(DW), .PKT_LEN(PL)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .m_axis     (m_axis)
  );

  always #5 rclk = ~rclk;

  // core model: registered read, empty reflects words already read
  assign fifo_empty = (wr_n == rd_n);
  always @(posedge rclk)
    if (fifo_ren) begin
      fifo_rdata <= mem[rd_n];
      rd_n       <= rd_n + 1;
    end

  // monitor: record beats, track occ+pend and data stability under backpressure
  always @(negedge rclk) begin
    cyc <= cyc + 1;
    if (fifo_ren) nren <= nren + 1;
    if (m_axis.tvalid && m_axis.tready) begin
      got[ngot] <= m_axis.tdata;
      gl[ngot]  <= m_axis.tlast;
      gc[ngot]  <= cyc;
      ngot      <= ngot + 1;
    end
    if (!rrst_n) lvl <= 0;
    else begin
      if (lvl > 2) viol <= viol + 1;
      lvl <= lvl + int'(fifo_ren) - int'(m_axis.tvalid && m_axis.tready);
    end
    if (rrst_n && pv && !pr && (!m_axis.tvalid || m_axis.tdata !== pd)) stab <= stab + 1;
    pv <= rrst_n && m_axis.tvalid;
    pr <= m_axis.tready;
    pd <= m_axis.tdata;
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_got(input int target, input int bound);
    for (int t = 0; t < bound && ngot < target; t++) tick();
  endtask

  task automatic test_reset();
    m_axis.tready = 1'b0;
    #2 rrst_n = 1'b0;
    tick();
    wr_n = 64;
    tick();
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", fifo_ren); end
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis.tvalid); end
    checks++; if (m_axis.tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h want 00", m_axis.tdata); end
    checks++; if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis.tlast); end
  endtask

  task automatic test_stream();
    int bad_d, bad_c;
    bad_d = 0;
    bad_c = 0;
    m_axis.tready = 1'b1;
    rrst_n = 1'b1;
    #1;
    checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL stream_ren_k: got %b want 1", fifo_ren); end
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL stream_vld_k: got %b want 0", m_axis.tvalid); end
    tick();
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL stream_vld_k1: got %b want 0", m_axis.tvalid); end
    tick();
    checks++; if (m_axis.tvalid !== 1'b1) begin errors++; $display("FAIL stream_vld_k2: got %b want 1", m_axis.tvalid); end
    checks++; if (m_axis.tdata !== 8'h00) begin errors++; $display("FAIL stream_first: got %h want 00", m_axis.tdata); end
    wait_got(64, 200);
    checks++; if (ngot !== 64) begin errors++; $display("FAIL stream_count: got %0d want 64", ngot); end
    for (int i = 0; i < 64; i++) begin
      if (got[i] !== 8'(i)) bad_d++;
      if (gc[i] - gc[0] != i) bad_c++;
    end
    checks++; if (bad_d !== 0) begin errors++; $display("FAIL stream_data: %0d wrong beats want 0", bad_d); end
    checks++; if (bad_c !== 0) begin errors++; $display("FAIL stream_gap: %0d non-consecutive beats want 0", bad_c); end
  endtask

  task automatic test_backpressure();
    int r0, b, bad;
    bad = 0;
    tick();
    m_axis.tready = 1'b0;
    r0 = nren;
    wr_n = 74;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (m_axis.tvalid && m_axis.tdata !== 8'd64) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d cycles with wrong tdata want 0", bad); end
    checks++; if (m_axis.tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %b want 1", m_axis.tvalid); end
    checks++; if (m_axis.tdata !== 8'd64) begin errors++; $display("FAIL bp_tdata: got %0d want 64", m_axis.tdata); end
    checks++; if (nren - r0 !== 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", nren - r0); end
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL bp_ren_idle: got %b want 0", fifo_ren); end
    b = ngot;
    m_axis.tready = 1'b1;
    wait_got(b + 10, 60);
    checks++; if (ngot - b !== 10) begin errors++; $display("FAIL bp_count: got %0d want 10", ngot - b); end
    bad = 0;
    for (int i = 0; i < 10; i++) if (got[b+i] !== 8'(64 + i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_order: %0d wrong beats want 0", bad); end
  endtask

  task automatic test_toggle();
    int b, bad;
    bad = 0;
    b = ngot;
    wr_n = 138;
    for (int t = 0; t < 400 && ngot < b + 64; t++) begin
      tick();
      m_axis.tready = ~m_axis.tready;
    end
    m_axis.tready = 1'b1;
    checks++; if (ngot - b !== 64) begin errors++; $display("FAIL toggle_count: got %0d want 64", ngot - b); end
    for (int i = 0; i < 64; i++) if (got[b+i] !== 8'(74 + i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_order: %0d wrong beats want 0", bad); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL occ_pend_le2: %0d violations want 0", viol); end
    checks++; if (stab !== 0) begin errors++; $display("FAIL axis_stable: %0d violations want 0", stab); end
  endtask

  task automatic test_async_reset();
    int r0, b, bad;
    bad = 0;
    tick();
    m_axis.tready = 1'b0;
    r0 = nren;
    wr_n = 148;
    repeat (5) tick();
    checks++; if (m_axis.tvalid !== 1'b1) begin errors++; $display("FAIL ar_pre_tvalid: got %b want 1", m_axis.tvalid); end
    checks++; if (m_axis.tdata !== 8'd138) begin errors++; $display("FAIL ar_pre_tdata: got %0d want 138", m_axis.tdata); end
    checks++; if (nren - r0 !== 2) begin errors++; $display("FAIL ar_pre_reads: got %0d want 2", nren - r0); end
    rrst_n = 1'b0;
    #1;
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL ar_tvalid: got %b want 0", m_axis.tvalid); end
    checks++; if (m_axis.tdata !== 8'h00) begin errors++; $display("FAIL ar_tdata: got %h want 00", m_axis.tdata); end
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL ar_ren: got %b want 0", fifo_ren); end
    tick();
    rrst_n = 1'b1;
    m_axis.tready = 1'b1;
    b = ngot;
    wait_got(b + 8, 60);
    checks++; if (ngot - b !== 8) begin errors++; $display("FAIL ar_count: got %0d want 8", ngot - b); end
    for (int i = 0; i < 8; i++) if (got[b+i] !== 8'(140 + i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ar_resume: %0d wrong beats want 0 (first %0d want 140)", bad, got[b]); end
  endtask

  task automatic test_tlast();
    int b, b0, bad;
    logic e;
    bad = 0;
    b = ngot;
    b0 = ngot - 8;
    wr_n = 160;
    wait_got(b + 12, 60);
    checks++; if (ngot - b !== 12) begin errors++; $display("FAIL tlast_count: got %0d want 12", ngot - b); end
    for (int j = 0; j < 20; j++) begin
`ifdef AXIS_FIFO_RD_TLAST_EN
      e = (j % PL) == PL - 1;
`else
      e = 1'b0;
`endif
      if (gl[b0+j] !== e) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tlast_pattern: %0d wrong beats want 0", bad); end
  endtask

  task automatic test_single();
    int b, r0;
    b = ngot;
    r0 = nren;
    wr_n = 161;
    repeat (8) tick();
    checks++; if (ngot - b !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", ngot - b); end
    checks++; if (got[b] !== 8'd160) begin errors++; $display("FAIL single_data: got %0d want 160", got[b]); end
    checks++; if (nren - r0 !== 1) begin errors++; $display("FAIL single_reads: got %0d want 1", nren - r0); end
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", m_axis.tvalid); end
    checks++; if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL single_tlast: got %b want 0", m_axis.tlast); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_async_reset();
    test_tlast();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule
